// File: rtl/usb_clk_monitor_pkg.sv
// ---------------------------------------------------------------------------
// usb_clk_monitor_pkg
// Shared definitions for the USB interface clock monitor:
//   - monitor FSM state encoding
//   - default gate window and acceptance limits for a 50 MHz system clock
//     supervising a 48 MHz IFCLK that is divided down to a toggle (every 8
//     IFCLK cycles the toggle inverts, so 6 M edges/s reach the monitor)
// ---------------------------------------------------------------------------
package usb_clk_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    localparam int unsigned SYSCLK_HZ     = 32'd50_000_000;
    localparam int unsigned IFCLK_HZ      = 32'd48_000_000;
    // IFCLK cycles between inversions of the toggle
    localparam int unsigned TGL_DIV       = 32'd8;
    // Gate windows per second (1 ms window)
    localparam int unsigned GATES_PER_SEC = 32'd1_000;

    localparam int unsigned DEF_GATE_CYCLES  = SYSCLK_HZ / GATES_PER_SEC;
    // Every inversion of the toggle is one counted edge
    localparam int unsigned DEF_EXP_NOM      = IFCLK_HZ / TGL_DIV / GATES_PER_SEC;
    // +/-1 % acceptance band around nominal
    localparam int unsigned DEF_EXP_TOL      = DEF_EXP_NOM / 32'd100;
    localparam int unsigned DEF_EXP_MIN      = DEF_EXP_NOM - DEF_EXP_TOL;
    localparam int unsigned DEF_EXP_MAX      = DEF_EXP_NOM + DEF_EXP_TOL;
    localparam int unsigned DEF_GOOD_WINDOWS = 32'd3;
    localparam int unsigned DEF_CNT_W        = 32'd16;

endpackage

// File: rtl/usb_clk_monitor_sync.sv
// ---------------------------------------------------------------------------
// tgl_edge_sync
// Brings an asynchronous toggle into the clk domain through two flops and
// uses a third flop to detect a change. Both polarities of the toggle give
// a one-cycle edge_pulse.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tgl        asynchronous toggle input
//   edge_pulse one-cycle pulse per toggle inversion (sync2 xor sync3)
// ---------------------------------------------------------------------------
module tgl_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl,
    output logic edge_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;

    // Synchronizer chain plus delay stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= tgl;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign edge_pulse = sync2_r ^ sync3_r;

endmodule

// File: rtl/usb_clk_monitor.sv
// ---------------------------------------------------------------------------
// usb_clk_monitor
// Measures the edge rate of a toggle derived from the USB IFCLK over fixed
// gate windows in the system clock domain. After a settle window, windows
// run back to back; each result is published on freq_count/freq_valid and
// judged against [EXP_MIN, EXP_MAX]. GOOD_WINDOWS consecutive good windows
// raise clk_ok and release usb_rst_n; any bad window drops both at once and
// a drop of clk_ok by a bad window sets the sticky loss_flag.
// Ports:
//   clk        50 MHz system clock
//   reset_n    asynchronous active-low reset
//   enable     run enable (level); low aborts and returns to IDLE
//   ref_tgl    asynchronous toggle from the IFCLK domain
//   clr_loss   pulse, clears loss_flag (a simultaneous set wins)
//   freq_count edge count of the last completed window
//   freq_valid one-cycle pulse when freq_count is updated
//   clk_ok     USB clock judged stable
//   usb_rst_n  active-low reset request to the USB domain
//   loss_flag  sticky: clk_ok fell because of a bad window
// ---------------------------------------------------------------------------
module usb_clk_monitor
    import usb_clk_monitor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int unsigned EXP_MIN      = DEF_EXP_MIN,
    parameter int unsigned EXP_MAX      = DEF_EXP_MAX,
    parameter int unsigned GOOD_WINDOWS = DEF_GOOD_WINDOWS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             ref_tgl,
    input  logic             clr_loss,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             clk_ok,
    output logic             usb_rst_n,
    output logic             loss_flag
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 32'd1;
    localparam int unsigned RUN_W  = $clog2(GOOD_WINDOWS + 32'd1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 32'd1);
    localparam logic [GATE_W-1:0] GATE_ZERO = GATE_W'(32'd0);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(EXP_MAX);
    localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(32'd0);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(32'd1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(GOOD_WINDOWS);

    mon_state_e        state_r;
    mon_state_e        state_nxt_s;
    logic [GATE_W-1:0] gate_r;
    logic [GATE_W-1:0] gate_nxt_s;
    logic [CNT_W-1:0]  edge_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_nxt_s;
    logic [CNT_W-1:0]  freq_count_r;
    logic [CNT_W-1:0]  freq_count_nxt_s;
    logic              freq_valid_r;
    logic              freq_valid_nxt_s;
    logic              clk_ok_r;
    logic              clk_ok_nxt_s;
    logic              usb_rst_n_r;
    logic              usb_rst_n_nxt_s;
    logic              loss_flag_r;
    logic              loss_flag_nxt_s;
    logic [RUN_W-1:0]  good_run_r;
    logic [RUN_W-1:0]  good_run_nxt_s;
    logic [RUN_W-1:0]  run_inc_s;
    logic [CNT_W-1:0]  edge_sum_s;
    logic              edge_s;
    logic              gate_last_s;
    logic              good_s;
    logic              loss_set_s;

    tgl_edge_sync u_ref_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .tgl        (ref_tgl),
        .edge_pulse (edge_s)
    );

    // Window arithmetic: running count including this cycle's edge, and verdict
    always_comb begin
        gate_last_s = (gate_r == GATE_LAST);
        edge_sum_s  = edge_cnt_r;
        if (edge_s && (edge_cnt_r != CNT_SAT)) begin
            edge_sum_s = edge_cnt_r + CNT_ONE;
        end else begin
            edge_sum_s = edge_cnt_r;
        end
        // A saturated counter means the true count is unknown, so reject it
        good_s = (edge_sum_s != CNT_SAT) && (edge_sum_s >= CNT_MIN) && (edge_sum_s <= CNT_MAX);
        if (good_run_r == RUN_MAX) begin
            run_inc_s = RUN_MAX;
        end else begin
            run_inc_s = good_run_r + RUN_ONE;
        end
    end

    // Next-state logic for the monitor FSM
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nxt_s = ST_SETTLE;
                ST_SETTLE: begin
                    if (gate_last_s) begin
                        state_nxt_s = ST_MEASURE;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end
                ST_MEASURE: state_nxt_s = ST_MEASURE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Next values for counters, window results and status outputs
    always_comb begin
        gate_nxt_s       = gate_r;
        edge_cnt_nxt_s   = edge_cnt_r;
        freq_count_nxt_s = freq_count_r;
        freq_valid_nxt_s = 1'b0;
        clk_ok_nxt_s     = clk_ok_r;
        usb_rst_n_nxt_s  = usb_rst_n_r;
        good_run_nxt_s   = good_run_r;
        loss_set_s       = 1'b0;
        if (!enable) begin
            // Abort: the running window is dropped without a result
            gate_nxt_s      = GATE_ZERO;
            edge_cnt_nxt_s  = CNT_ZERO;
            clk_ok_nxt_s    = 1'b0;
            usb_rst_n_nxt_s = 1'b0;
            good_run_nxt_s  = RUN_ZERO;
        end else if (state_r == ST_IDLE) begin
            gate_nxt_s     = GATE_ZERO;
            edge_cnt_nxt_s = CNT_ZERO;
        end else if (gate_last_s) begin
            // Last gate cycle: its edge is already in edge_sum_s; the next
            // cycle opens a fresh window with no dead time
            gate_nxt_s     = GATE_ZERO;
            edge_cnt_nxt_s = CNT_ZERO;
            if (state_r == ST_MEASURE) begin
                freq_count_nxt_s = edge_sum_s;
                freq_valid_nxt_s = 1'b1;
                if (good_s) begin
                    good_run_nxt_s  = run_inc_s;
                    clk_ok_nxt_s    = (run_inc_s == RUN_MAX);
                    usb_rst_n_nxt_s = (run_inc_s == RUN_MAX);
                end else begin
                    good_run_nxt_s  = RUN_ZERO;
                    clk_ok_nxt_s    = 1'b0;
                    usb_rst_n_nxt_s = 1'b0;
                    loss_set_s      = clk_ok_r;
                end
            end else begin
                // Settle window result is discarded
                freq_count_nxt_s = freq_count_r;
            end
        end else begin
            gate_nxt_s     = gate_r + GATE_ONE;
            edge_cnt_nxt_s = edge_sum_s;
        end
    end

    // Sticky loss flag: a set in the same cycle as a clear wins
    always_comb begin
        if (loss_set_s) begin
            loss_flag_nxt_s = 1'b1;
        end else if (clr_loss) begin
            loss_flag_nxt_s = 1'b0;
        end else begin
            loss_flag_nxt_s = loss_flag_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_r       <= GATE_ZERO;
            edge_cnt_r   <= CNT_ZERO;
            freq_count_r <= CNT_ZERO;
            freq_valid_r <= 1'b0;
            clk_ok_r     <= 1'b0;
            usb_rst_n_r  <= 1'b0;
            loss_flag_r  <= 1'b0;
            good_run_r   <= RUN_ZERO;
        end else begin
            gate_r       <= gate_nxt_s;
            edge_cnt_r   <= edge_cnt_nxt_s;
            freq_count_r <= freq_count_nxt_s;
            freq_valid_r <= freq_valid_nxt_s;
            clk_ok_r     <= clk_ok_nxt_s;
            usb_rst_n_r  <= usb_rst_n_nxt_s;
            loss_flag_r  <= loss_flag_nxt_s;
            good_run_r   <= good_run_nxt_s;
        end
    end

    assign freq_count = freq_count_r;
    assign freq_valid = freq_valid_r;
    assign clk_ok     = clk_ok_r;
    assign usb_rst_n  = usb_rst_n_r;
    assign loss_flag  = loss_flag_r;

endmodule

// File: tb/tb_usb_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_usb_clk_monitor
// Scoreboard bench for usb_clk_monitor with shortened windows (1000 cycles,
// accept 115..125, 3 good windows). Stimulus pushes the expected window
// result; a forked monitor pops and compares on every freq_valid.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_clk_monitor;

    localparam int G    = 1000;
    localparam int EMIN = 115;
    localparam int EMAX = 125;
    localparam int GW   = 3;
    localparam int CW   = 16;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          enable    = 1'b0;
    logic          clr_loss  = 1'b0;
    logic          sync_tgl  = 1'b0;
    logic          async_tgl = 1'b0;
    logic          async_run = 1'b0;
    logic          sync_mode = 1'b0;
    logic          ref_tgl;
    logic [CW-1:0] freq_count;
    logic          freq_valid;
    logic          clk_ok;
    logic          usb_rst_n;
    logic          loss_flag;

    typedef struct {
        int lo;
        int hi;
        bit ok;
        bit loss;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    // Reference model: consecutive good windows since enable, and loss state
    int   m_run  = 0;
    bit   m_ok   = 1'b0;
    bit   m_loss = 1'b0;

    assign ref_tgl = sync_mode ? sync_tgl : async_tgl;

    usb_clk_monitor #(
        .GATE_CYCLES  (G),
        .EXP_MIN      (EMIN),
        .EXP_MAX      (EMAX),
        .GOOD_WINDOWS (GW),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ref_tgl    (ref_tgl),
        .clr_loss   (clr_loss),
        .freq_count (freq_count),
        .freq_valid (freq_valid),
        .clk_ok     (clk_ok),
        .usb_rst_n  (usb_rst_n),
        .loss_flag  (loss_flag)
    );

    initial forever #10 clk = ~clk;

    // Free-running nominal IFCLK toggle: inverts every 166.667 ns (6 MHz edges)
    initial begin
        #3.1;
        forever begin
            #166.667;
            if (async_run) async_tgl = ~async_tgl;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Expected effect of one completed window on the status outputs
    task automatic model_window(input int lo, input int hi, input bit good);
        if (good) begin
            if (m_run < GW) m_run++;
        end else begin
            if (m_ok) m_loss = 1'b1;
            m_run = 0;
        end
        m_ok = (m_run >= GW);
        exp_q.push_back('{lo, hi, m_ok, m_loss});
    endtask

    task automatic model_disable();
        m_run = 0;
        m_ok  = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && freq_valid) begin
                chk("expectation_pending", exp_q.size(), 1, 1 << 20);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("freq_count", int'(freq_count), e.lo, e.hi);
                    chk("clk_ok", int'(clk_ok), int'(e.ok), int'(e.ok));
                    chk("usb_rst_n", int'(usb_rst_n), int'(e.ok), int'(e.ok));
                    chk("loss_flag", int'(loss_flag), int'(e.loss), int'(e.loss));
                end
            end
        end
    endtask

    // Raise enable; return in cycle 998 after the sampling edge so that
    // toggles issued from here on are detected from window offset 0
    task automatic start_enable();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        repeat (998) @(posedge clk);
    endtask

    task automatic run_async_win();
        model_window(119, 121, 1'b1);
        repeat (G) @(negedge clk);
    endtask

    // One window with exactly n detected edges. Iteration k toggles the
    // input so that the edge is detected at window offset k. clr_k pulses
    // clr_loss at iteration k (k=1 coincides with the previous window end);
    // dis_k drops enable at iteration k and abandons the window.
    task automatic run_win(input int n, input bit f0, input bit f999, input int clr_k, input int dis_k);
        bit plan [G];
        int need;
        int slots;
        need  = n;
        slots = G;
        for (int k = 0; k < G; k++) plan[k] = 1'b0;
        if (f0)   begin plan[0]   = 1'b1; need--; slots--; end
        if (f999) begin plan[G-1] = 1'b1; need--; slots--; end
        for (int k = 0; k < G; k++) begin
            if (!((k == 0 && f0) || (k == G-1 && f999))) begin
                if (need > 0 && int'($urandom_range(slots - 1, 0)) < need) begin
                    plan[k] = 1'b1;
                    need--;
                end
                slots--;
            end
        end
        for (int k = 0; k < G; k++) begin
            @(negedge clk);
            clr_loss = (k == clr_k);
            if (clr_k >= 2 && k == clr_k) m_loss = 1'b0;
            if (clr_k >= 1 && k == clr_k + 1) chk("loss_after_clr", int'(loss_flag), int'(m_loss), int'(m_loss));
            if (k == dis_k) begin
                enable   = 1'b0;
                clr_loss = 1'b0;
                model_disable();
                return;
            end
            if (plan[k]) sync_tgl = ~sync_tgl;
        end
        clr_loss = 1'b0;
        model_window(n, n, (n >= EMIN) && (n <= EMAX));
    endtask

    function automatic int rand_good();
        return int'($urandom_range(EMAX, EMIN));
    endfunction

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_freq_count", int'(freq_count), 0, 0);
        chk("rst_freq_valid", int'(freq_valid), 0, 0);
        chk("rst_clk_ok", int'(clk_ok), 0, 0);
        chk("rst_usb_rst_n", int'(usb_rst_n), 0, 0);
        chk("rst_loss_flag", int'(loss_flag), 0, 0);
        reset_n = 1'b1;

        // Nominal asynchronous IFCLK toggle
        async_run = 1'b1;
        start_enable();
        repeat (4) run_async_win();
        repeat (500) @(negedge clk);
        chk("ok_before_disable", int'(clk_ok), 1, 1);
        enable = 1'b0;
        model_disable();
        repeat (2) @(negedge clk);
        chk("dis_clk_ok", int'(clk_ok), 0, 0);
        chk("dis_usb_rst_n", int'(usb_rst_n), 0, 0);
        chk("dis_loss_flag", int'(loss_flag), int'(m_loss), int'(m_loss));
        repeat (1500) @(negedge clk);
        async_run = 1'b0;
        sync_tgl  = async_tgl;
        sync_mode = 1'b1;
        repeat (10) @(negedge clk);

        // Exact edge counts, boundaries, loss and clear
        start_enable();
        run_win(rand_good(), 1'b0, 1'b0, -1, -1);
        run_win(115, 1'b0, 1'b0, -1, -1);
        run_win(125, 1'b0, 1'b0, -1, -1);
        run_win(114, 1'b0, 1'b0, -1, -1);
        run_win(126, 1'b0, 1'b0, 300, -1);
        run_win(115, 1'b0, 1'b1, -1, -1);
        run_win(120, 1'b1, 1'b0, -1, -1);
        run_win(125, 1'b1, 1'b1, -1, -1);
        run_win(0, 1'b0, 1'b0, -1, -1);
        run_win(int'($urandom_range(60, 0)), 1'b0, 1'b0, 1, -1);
        repeat (3) run_win(rand_good(), 1'b0, 1'b0, -1, -1);
        run_win(rand_good(), 1'b0, 1'b0, -1, 500);
        repeat (2) @(negedge clk);
        chk("dis2_clk_ok", int'(clk_ok), 0, 0);
        chk("dis2_usb_rst_n", int'(usb_rst_n), 0, 0);
        chk("dis2_loss_flag", int'(loss_flag), int'(m_loss), int'(m_loss));
        repeat (1500) @(negedge clk);

        // Re-enable: settle plus three good windows, then reset mid-window
        start_enable();
        repeat (3) run_win(rand_good(), 1'b0, 1'b0, -1, -1);
        repeat (300) @(negedge clk);
        chk("ok_before_reset", int'(clk_ok), 1, 1);
        #5;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("arst_freq_count", int'(freq_count), 0, 0);
        chk("arst_freq_valid", int'(freq_valid), 0, 0);
        chk("arst_clk_ok", int'(clk_ok), 0, 0);
        chk("arst_usb_rst_n", int'(usb_rst_n), 0, 0);
        chk("arst_loss_flag", int'(loss_flag), 0, 0);
        model_disable();
        m_loss = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_clk_monitor.md
Name: usb_clk_monitor

Overview:
- Supervises the 48 MHz USB interface clock from the 50 MHz system domain.
- Counts edges of a slow toggle derived from IFCLK over a fixed gate window, then checks the count against a window.
- Releases a USB-side reset request only after several consecutive good windows.
- Drops clock-ok and sets a sticky loss flag when the clock disappears or drifts. Sits beside the clock/reset generator and gates the USB FIFO logic.

Parameters:
- GATE_CYCLES, 50000, gate window length in clk cycles (1 ms at 50 MHz)
- EXP_MIN, 5940, minimum acceptable edge count per window (inclusive)
- EXP_MAX, 6060, maximum acceptable edge count per window (inclusive)
- GOOD_WINDOWS, 3, consecutive good windows required before release
- CNT_W, 16, width of edge counter and freq_count

Ports:
- clk  input  1  50 MHz system clock; single clock domain
- reset_n  input  1  asynchronous active-low reset, synchronously released upstream
- enable  input  1  monitor run enable, level
- ref_tgl  input  1  asynchronous toggle from IFCLK domain, inverts every 8 IFCLK cycles (6 MHz edge rate nominal)
- clr_loss  input  1  single-cycle pulse, clears loss_flag
- freq_count  output  CNT_W  edge count of last completed window
- freq_valid  output  1  one-cycle pulse, freq_count updated
- clk_ok  output  1  USB clock judged stable
- usb_rst_n  output  1  active-low reset request to USB-domain logic
- loss_flag  output  1  sticky: clk_ok fell from 1 to 0

Behaviour:
- Decided: one clock (clk), asynchronous active-low reset (reset_n). Every register is cleared by reset_n low, independent of clk.
- Reset values: freq_count=0, freq_valid=0, clk_ok=0, usb_rst_n=0, loss_flag=0, FSM=IDLE, all counters 0.
- ref_tgl sync: two flops, then a third flop for edge detect. An edge is sync2 XOR sync3, so both polarities count.
- Gate counter runs 0..GATE_CYCLES-1. The edge counter increments on each detected edge and saturates at all-ones.
- FSM states:
  - IDLE: counters held at 0. When enable=1, go to SETTLE.
  - SETTLE: runs one full window, result discarded (flushes sync pipeline). At gate=GATE_CYCLES-1, go to MEASURE.
  - MEASURE: windows run back-to-back, no dead cycles. An edge detected in the last cycle (gate=GATE_CYCLES-1) belongs to the ending window. The next cycle starts the new window at edge count 0, plus 1 if an edge is detected in that cycle.
  - Any state: enable=0 forces IDLE next cycle.
- Window end, registered one cycle after the last gate cycle:
  - freq_count is loaded.
  - freq_valid pulses for 1 cycle.
  - good = EXP_MIN <= count <= EXP_MAX.
- Good window:
  - good_run increments, saturating at GOOD_WINDOWS.
  - When good_run reaches GOOD_WINDOWS: clk_ok=1 and usb_rst_n=1, in the same cycle as that freq_valid.
- Bad window:
  - good_run=0, clk_ok=0, usb_rst_n=0, all in the freq_valid cycle.
  - If clk_ok was 1, loss_flag is set.
- Saturated edge counter compares as bad.
- Entering IDLE via enable=0: clk_ok=0, usb_rst_n=0, good_run=0. No freq_valid for the aborted window. freq_count and loss_flag keep their values. Dropping clk_ok by disable does NOT set loss_flag.
- clr_loss and a set event in the same cycle: set wins.
- Reset mid-window: everything returns to reset values immediately, with no partial result.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SETTLE, MEASURE)
  - default gate/limit constants for 50 MHz clk and 48 MHz IFCLK
  - toggle divide ratio (8)
- One sub-module, tgl_edge_sync: 3-flop synchronizer plus edge pulse, reusable for other cross-domain toggles.

Test Plan:
- Bench override for all tests: GATE_CYCLES=1000, EXP_MIN=115, EXP_MAX=125, GOOD_WINDOWS=3.
- Nominal: ref_tgl period 333.3 ns, enable=1 -> SETTLE window, then freq_valid every 1000 cycles with freq_count=120±1. clk_ok and usb_rst_n rise with the 3rd freq_valid, i.e. 4000 cycles + 1 after enable.
- Clock loss: after clk_ok=1, stop ref_tgl -> next freq_valid has freq_count≈0 (partial) or 0. Same cycle: clk_ok=0, usb_rst_n=0, loss_flag=1. Pulse clr_loss -> loss_flag=0.
- Boundary counts: force exactly 115, 125, 114 and 126 edges per window -> good, good, bad, bad. The bad windows reset good_run, so 3 further good windows are needed before clk_ok returns.
- Last-cycle edge: place an edge exactly at gate=999 -> counted in the ending window. An edge at gate=0 of the next window -> counted in the new one. No edge lost or double-counted.
- Disable/reset mid-window: enable=0 at gate=500 -> IDLE, no freq_valid, clk_ok=0, loss_flag unchanged. Re-enable -> full SETTLE plus 3 good windows again. Assert reset_n low mid-window -> all outputs 0 within the same cycle, asynchronously.
- Simultaneous: clr_loss pulsed in the same cycle as a loss event -> loss_flag=1.
